// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake bundle for muldiv_unit.
//   slave  : the unit (accepts requests, produces results)
//   master : the requester (drives operands, consumes results)
interface muldiv_unit_if #(parameter int XLEN = 32);
   logic            req_valid_i;
   logic            req_ready_o;
   logic [XLEN-1:0] oper1_i;
   logic [XLEN-1:0] oper2_i;
   logic [2:0]      sel_op_i;
   logic            kill_i;
   logic            result_valid_o;
   logic            result_ready_i;
   logic [XLEN-1:0] result_o;
   modport slave (
      input  req_valid_i, oper1_i, oper2_i, sel_op_i, kill_i, result_ready_i,
      output req_ready_o, result_valid_o, result_o
   );
   modport master (
      output req_valid_i, oper1_i, oper2_i, sel_op_i, kill_i, result_ready_i,
      input  req_ready_o, result_valid_o, result_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit, one bit per cycle.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : request (valid/ready, operands, op select, kill) and result (valid/ready, data)
module muldiv_unit #(parameter int XLEN = 32) (
   input  logic         clk_i,
   input  logic         rst_ni,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic [2*XLEN-1:0] work_q, work_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [2:0]        op_in;
   logic              a_signed, b_signed, a_neg, b_neg, accept, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, quo, rem, fin;
   logic [XLEN:0]     add_sum, rem_sh, diff;
   logic [2*XLEN-1:0] step, prod;

   // Both algorithms run on magnitudes; the sign is restored on the final step.
   // For multiply, opnd_q holds the multiplicand and the low half of work_q the
   // multiplier; for divide, opnd_q holds the divisor and work_q = {rem, quo}.
   always_comb begin
      op_in    = bus.sel_op_i;
      a_signed = (op_in == 3'd1) | (op_in == 3'd2) | (op_in == 3'd4) | (op_in == 3'd6);
      b_signed = (op_in == 3'd1) | (op_in == 3'd4) | (op_in == 3'd6);
      a_neg    = a_signed & bus.oper1_i[XLEN-1];
      b_neg    = b_signed & bus.oper2_i[XLEN-1];
      a_mag    = a_neg ? -bus.oper1_i : bus.oper1_i;
      b_mag    = b_neg ? -bus.oper2_i : bus.oper2_i;
      div_zero = op_in[2] & (bus.oper2_i == '0);
      div_ovf  = op_in[2] & ~op_in[0] & (bus.oper1_i == MIN_NEG) & (bus.oper2_i == '1);
      accept   = (state_q == IDLE) & bus.req_valid_i & ~bus.kill_i;
      add_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      // Partial remainder after the left shift needs one extra bit before the trial subtract.
      rem_sh   = work_q[2*XLEN-1:XLEN-1];
      diff     = rem_sh - {1'b0, opnd_q};
      step     = op_q[2] ? (diff[XLEN] ? {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0}
                                       : {diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1})
                         : (work_q[0] ? {add_sum, work_q[XLEN-1:1]}
                                      : {1'b0, work_q[2*XLEN-1:1]});
      prod     = qneg_q ? -step : step;
      quo      = qneg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      rem      = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
      fin      = op_q[2] ? (op_q[1] ? rem : quo)
                         : ((op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (accept) begin
         op_d   = op_in;
         qneg_d = a_neg ^ b_neg;
         rneg_d = a_neg;
         opnd_d = op_in[2] ? b_mag : a_mag;
         work_d = {{XLEN{1'b0}}, op_in[2] ? a_mag : b_mag};
         cnt_d  = '0;
         if (div_zero | div_ovf) begin
            state_d  = DONE;
            result_d = div_zero ? (op_in[1] ? bus.oper1_i : '1) : (op_in[1] ? '0 : MIN_NEG);
         end else begin
            state_d = CALC;
         end
      end else if (state_q == CALC) begin
         work_d = step;
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d  = DONE;
            result_d = fin;
         end
      end else if ((state_q == DONE) & bus.result_ready_i) begin
         state_d  = IDLE;
         result_d = '0;
      end
      if (bus.kill_i & (state_q != IDLE)) begin
         state_d  = IDLE;
         result_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         opnd_q   <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         work_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.req_ready_o    = (state_q == IDLE);
   assign bus.result_valid_o = (state_q == DONE);
   assign bus.result_o       = result_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid_i  input  1  operation request.
REQ-005 SHALL have port req_ready_o  output  1  unit can accept request.
REQ-006 SHALL have port oper1_i  input  XLEN  operand 1 / dividend / multiplicand.
REQ-007 SHALL have port oper2_i  input  XLEN  operand 2 / divisor / multiplier.
REQ-008 SHALL have port sel_op_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port kill_i  input  1  abort in-flight operation (pipeline flush).
REQ-010 SHALL have port result_valid_o  output  1  result available.
REQ-011 SHALL have port result_ready_i  input  1  consumer takes result.
REQ-012 SHALL have port result_o  output  XLEN  result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; req_ready_o = (state==IDLE).
REQ-014 SHALL accept a request on a rising edge with req_valid_i & req_ready_o (cycle T), registering operands and sel_op_i; inputs ignored otherwise.
REQ-015 SHALL, for normal operations, move IDLE->CALC at T, execute one radix-2 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle for exactly XLEN cycles, then enter DONE with result_valid_o high in cycle T+XLEN+1.
REQ-016 SHALL treat operands as signed/unsigned per RV32M: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned; DIV/REM signed, DIVU/REMU unsigned.
REQ-017 SHALL return low XLEN bits of the 2*XLEN product for MUL, high XLEN bits for MULH/MULHSU/MULHU.
REQ-018 SHALL round signed division toward zero; remainder sign equals dividend sign.
REQ-019 SHALL, on divisor zero, go IDLE->DONE directly (result_valid_o in T+1): DIV/DIVU = all ones, REM/REMU = oper1.
REQ-020 SHALL, on signed overflow (DIV/REM, oper1 = most-negative, oper2 = all ones), go IDLE->DONE directly: DIV = most-negative value, REM = 0.
REQ-021 SHALL hold result_o and result_valid_o stable in DONE until result_ready_i high; on that edge return to IDLE (req_ready_o high next cycle; no same-cycle accept).
REQ-022 SHALL, on kill_i high in CALC or DONE, return to IDLE on that edge with result_valid_o low next cycle and no result delivered; kill_i in IDLE blocks acceptance in that cycle.
REQ-023 SHALL drive result_o = 0 whenever result_valid_o is low.
REQ-024 SHALL have a 2*XLEN-bit working register plus a step counter of clog2(XLEN)+1 bits; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously enter IDLE: req_ready_o=1, result_valid_o=0, result_o=0, counter and working registers 0.
REQ-026 SHALL abandon any in-flight operation on reset, including mid-CALC and DONE, with no result emitted after release.
REQ-027 SHALL begin accepting requests on the first rising edge after rst_ni deasserts.

Verification (XLEN=32)
REQ-028 SHALL verify MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB at T+33; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 SHALL verify DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU -> 2, each at T+33.
REQ-030 SHALL verify DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0, each with result_valid_o at T+1.
REQ-031 SHALL verify backpressure: result_ready_i low 10 cycles after DONE -> result_o and result_valid_o stable, req_ready_o low; ready high -> IDLE next cycle.
REQ-032 SHALL verify kill_i at T+10 of a DIV -> no result_valid_o, req_ready_o high at T+11, next MUL 3x4 -> 12 correct.
REQ-033 SHALL verify rst_ni low at T+5 of MULHU -> outputs at reset values immediately, no result after release, subsequent REMU 9/4 -> 1.
